// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if
//   Bundles the pipeline hazard inputs, the front-end control outputs and the
//   status/performance outputs of hazard_stall_controller.
//   master : the pipeline side. It drives the stage control bits, register
//            addresses, branch info and ext_stall, and observes the outputs.
//   slave  : the controller side. It drives PCWrite, IFIDWrite, Bolha,
//            Flush, state, stall_cycles and flush_cycles.
interface hazard_stall_controller_if #(
   parameter int REG_W = 5
);
   logic             IDEX_RegWrite;
   logic             IDEX_MemRead;
   logic             EXMEM_MemRead;
   logic [REG_W-1:0] IDEX_RegisterRd;
   logic [REG_W-1:0] EXMEM_RegisterRd;
   logic [REG_W-1:0] IFID_Register1;
   logic [REG_W-1:0] IFID_Register2;
   logic             branch;
   logic             jalr;
   logic             Jump;
   logic             predicted;
   logic             ext_stall;
   logic             PCWrite;
   logic             IFIDWrite;
   logic             Bolha;
   logic             Flush;
   logic [1:0]       state;
   logic [31:0]      stall_cycles;
   logic [31:0]      flush_cycles;

   modport master (
      output IDEX_RegWrite, IDEX_MemRead, EXMEM_MemRead,
             IDEX_RegisterRd, EXMEM_RegisterRd, IFID_Register1, IFID_Register2,
             branch, jalr, Jump, predicted, ext_stall,
      input  PCWrite, IFIDWrite, Bolha, Flush, state, stall_cycles, flush_cycles
   );

   modport slave (
      input  IDEX_RegWrite, IDEX_MemRead, EXMEM_MemRead,
             IDEX_RegisterRd, EXMEM_RegisterRd, IFID_Register1, IFID_Register2,
             branch, jalr, Jump, predicted, ext_stall,
      output PCWrite, IFIDWrite, Bolha, Flush, state, stall_cycles, flush_cycles
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Registered hazard/flush controller for the RV32I pipeline. Detects
//   ALU->branch/JALR, load->branch/JALR, load-use and misprediction hazards,
//   and holds a stall (bubbles) or a front-end flush for a parametrised
//   number of cycles with a down-counting FSM. ext_stall freezes everything.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     hz    : hazard_stall_controller_if.slave (hazard inputs, PCWrite,
//             IFIDWrite, Bolha, Flush, state, stall_cycles, flush_cycles)
module hazard_stall_controller #(
   parameter int REG_W            = 5,
   parameter int LOAD_USE_STALL   = 1,
   parameter int BRANCH_DEP_STALL = 1,
   parameter int MISPREDICT_FLUSH = 1,
   parameter int CNT_W            = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   hazard_stall_controller_if.slave   hz
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] N_LOAD_BR = CNT_W'(LOAD_USE_STALL + BRANCH_DEP_STALL);
   localparam logic [CNT_W-1:0] N_BR_DEP  = CNT_W'(BRANCH_DEP_STALL);
   localparam logic [CNT_W-1:0] N_LOAD_US = CNT_W'(LOAD_USE_STALL);
   localparam logic [CNT_W-1:0] N_FLUSH   = CNT_W'(MISPREDICT_FLUSH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      stall_cycles_q, stall_cycles_d;
   logic [31:0]      flush_cycles_q, flush_cycles_d;

   logic             idex_match;
   logic             exmem_match;
   logic             br_any;
   logic             req_a, req_b, req_c, req_d;
   logic             hazard;
   logic [CNT_W-1:0] n_sel;
   logic             mispredict;

   logic             pc_write;
   logic             ifid_write;
   logic             bolha;
   logic             flush;

   // Hazard request decode
   always_comb begin
      idex_match  = (hz.IDEX_RegisterRd != '0) &&
                    ((hz.IDEX_RegisterRd == hz.IFID_Register1) ||
                     (hz.IDEX_RegisterRd == hz.IFID_Register2));
      exmem_match = (hz.EXMEM_RegisterRd != '0) &&
                    ((hz.EXMEM_RegisterRd == hz.IFID_Register1) ||
                     (hz.EXMEM_RegisterRd == hz.IFID_Register2));
      br_any      = hz.branch | hz.jalr;
      req_a       = hz.IDEX_MemRead  & idex_match  & br_any;
      req_b       = hz.IDEX_RegWrite & idex_match  & br_any;
      req_c       = hz.EXMEM_MemRead & exmem_match & br_any;
      req_d       = hz.IDEX_MemRead  & idex_match;
      hazard      = req_a | req_b | req_c | req_d;
      mispredict  = hz.predicted ^ hz.Jump;

      // Largest bubble count among the active requests wins
      n_sel = '0;
      if (req_a && (N_LOAD_BR > n_sel)) n_sel = N_LOAD_BR;
      if (req_b && (N_BR_DEP  > n_sel)) n_sel = N_BR_DEP;
      if (req_c && (N_BR_DEP  > n_sel)) n_sel = N_BR_DEP;
      if (req_d && (N_LOAD_US > n_sel)) n_sel = N_LOAD_US;
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bolha      = 1'b0;
      flush      = 1'b0;

      // Outputs are forced low while reset is held
      if (rst_n && !hz.ext_stall) begin
         unique case (state_q)
            STALL: begin
               bolha = 1'b1;
               if (cnt_q == CNT_ONE) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q - CNT_ONE;
               end
            end
            FLUSH: begin
               flush      = 1'b1;
               pc_write   = 1'b1;
               ifid_write = 1'b1;
               if (cnt_q == CNT_ONE) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q - CNT_ONE;
               end
            end
            default: begin
               if (hazard) begin
                  bolha = 1'b1;
                  // This cycle is the first bubble; the remainder is counted in STALL
                  if (n_sel > CNT_ONE) begin
                     state_d = STALL;
                     cnt_d   = n_sel - CNT_ONE;
                  end
               end else if (mispredict) begin
                  flush      = 1'b1;
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
                  if (N_FLUSH > CNT_ONE) begin
                     state_d = FLUSH;
                     cnt_d   = N_FLUSH - CNT_ONE;
                  end
               end else begin
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
               end
            end
         endcase
      end

      // Frozen cycles drive Bolha/Flush low, so the counters hold naturally
      stall_cycles_d = stall_cycles_q + 32'(bolha);
      flush_cycles_d = flush_cycles_q + 32'(flush);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         cnt_q          <= '0;
         stall_cycles_q <= '0;
         flush_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
         flush_cycles_q <= flush_cycles_d;
      end
   end

   assign hz.PCWrite      = pc_write;
   assign hz.IFIDWrite    = ifid_write;
   assign hz.Bolha        = bolha;
   assign hz.Flush        = flush;
   assign hz.state        = state_q;
   assign hz.stall_cycles = stall_cycles_q;
   assign hz.flush_cycles = flush_cycles_q;

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Registered, parametrised hazard and flush controller for the RV32I pipeline, sitting between the IF/ID and ID/EX pipeline registers and driving PC/IF-ID write enables, bubble insertion and front-end flush. It detects the same hazard classes as the current combinational unit: ALU-to-branch/JALR, load-to-branch/JALR, load-use and branch misprediction. A counter-based FSM holds a stall or flush for a parametrised number of cycles. It adds an external freeze input for slow memory and performance counters.

## Interface
- REG_W, 5: register address width.
- LOAD_USE_STALL, 1: bubbles for load-use (legal 1..7).
- BRANCH_DEP_STALL, 1: bubbles for ALU/EXMEM-load → branch/JALR dependency (legal 1..7).
- MISPREDICT_FLUSH, 1: cycles Flush is held on misprediction (legal 1..3).
- CNT_W, 4: width of internal cycle counter (must hold LOAD_USE_STALL+BRANCH_DEP_STALL).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IDEX_RegWrite, IDEX_MemRead, EXMEM_MemRead  in  1  stage control bits.
- IDEX_RegisterRd, EXMEM_RegisterRd  in  REG_W  destination registers.
- IFID_Register1, IFID_Register2  in  REG_W  ID-stage source registers.
- branch, jalr  in  1  ID-stage instruction is conditional branch / JALR.
- Jump, predicted  in  1  resolved outcome / predicted outcome.
- ext_stall  in  1  freeze request (memory not ready).
- PCWrite, IFIDWrite  out  1  write enables.
- Bolha  out  1  insert bubble into ID/EX.
- Flush  out  1  flush IF/ID.
- state  out  2  RUN=0, STALL=1, FLUSH=2.
- stall_cycles, flush_cycles  out  32  performance counters.

## Operation
- Dependency match on a register means rd ≠ 0 and rd equals IFID_Register1 or IFID_Register2.
- Hazard requests, evaluated only in RUN, each with its bubble count N:
  - A: IDEX_MemRead with IDEX match and (branch|jalr); N = LOAD_USE_STALL+BRANCH_DEP_STALL.
  - B: IDEX_RegWrite with IDEX match and (branch|jalr); N = BRANCH_DEP_STALL.
  - C: EXMEM_MemRead with EXMEM match and (branch|jalr); N = BRANCH_DEP_STALL.
  - D: IDEX_MemRead with IDEX match; N = LOAD_USE_STALL.
  - If several requests apply, the largest N is used.
- Priority, highest first:
  - ext_stall: PCWrite=0, IFIDWrite=0, Bolha=0, Flush=0. State, counter and perf counters hold.
  - In STALL: PCWrite=0, IFIDWrite=0, Bolha=1. All inputs are ignored.
  - In FLUSH: Flush=1, PCWrite=1, IFIDWrite=1, Bolha=0. Hazard inputs are ignored.
  - RUN with any hazard request: PCWrite=0, IFIDWrite=0, Bolha=1. If N>1, go to STALL with counter=N-1.
  - RUN with no hazard and predicted^Jump: Flush=1. If MISPREDICT_FLUSH>1, go to FLUSH with counter=MISPREDICT_FLUSH-1.
  - Otherwise: PCWrite=1, IFIDWrite=1, Bolha=0, Flush=0.
- STALL/FLUSH: counter decrements each non-frozen cycle. When counter==1 at a clock edge, the next state is RUN.
- stall_cycles increments on each clock edge where Bolha=1; flush_cycles increments on each edge where Flush=1. Both wrap modulo 2^32.

## Timing
- Outputs are combinational from state and inputs. There are no registered outputs, so a hazard is reported in the same cycle it is detected.
- Total stall length for one hazard is exactly N cycles of Bolha=1, not counting ext_stall cycles.
- Flush length is exactly MISPREDICT_FLUSH cycles of Flush=1, not counting ext_stall cycles.
- ext_stall extends the current state by one cycle per asserted cycle. Counting resumes where it stopped.
- Reset (asynchronous, mid-operation included):
  - state=RUN, counter=0, stall_cycles=0, flush_cycles=0.
  - While rst_n=0: PCWrite=0, IFIDWrite=0, Bolha=0, Flush=0.
- First cycle after rst_n rises: normal RUN evaluation.
- Misprediction coincident with a hazard in RUN: the hazard wins and Flush stays 0. The misprediction is re-evaluated once back in RUN.

## Test plan
- Defaults; IDEX_MemRead=1, IDEX_RegisterRd=5, IFID_Register1=5, branch=0 -> one cycle of PCWrite=0/IFIDWrite=0/Bolha=1, state stays 0, stall_cycles=1.
- LOAD_USE_STALL=2, BRANCH_DEP_STALL=1; IDEX load to x7, branch=1, IFID_Register2=7 -> Bolha=1 for exactly 3 cycles, state 0→1→1→0, then inputs deasserted give PCWrite=1.
- rd=0 on every hazard path with matching sources -> no stall, PCWrite=1, Bolha=0.
- MISPREDICT_FLUSH=2; predicted=1, Jump=0 -> Flush=1 for 2 cycles, state 0→2→0, flush_cycles=2.
- LOAD_USE_STALL=3; load-use stall with ext_stall=1 for 2 cycles in STALL -> all outputs 0 during freeze, total Bolha=1 cycles still 3, stall_cycles=3.
- rst_n pulled low in cycle 2 of a 3-cycle STALL -> outputs 0 immediately, state=0, counters=0; after release with no hazard, PCWrite=1.
